fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.

Interface
REQ-002 The block SHALL have ip_clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have ip_rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have op_imem_req  output  1  a one-cycle read request to instruction memory, accepted in the cycle it is high.
REQ-005 The block SHALL have op_imem_addr  output  32  the byte address of the request, always word-aligned.
REQ-006 The block SHALL have ip_imem_rdata  input  32  the read data from instruction memory.
REQ-007 The block SHALL have ip_imem_rvalid  input  1  the read-data strobe, arriving 1 or more cycles after the request.
REQ-008 The block SHALL have op_instr_from_imem  output  32  the instruction presented to the decoder.
REQ-009 The block SHALL have op_instr_valid  output  1  high when op_instr_from_imem holds a live instruction.
REQ-010 The block SHALL have op_pc  output  32  the address of the instruction on op_instr_from_imem.
REQ-011 The block SHALL have ip_stall  input  1  downstream hold; the presented instruction is not consumed this cycle.
REQ-012 The block SHALL have ip_redirect_valid  input  1  a one-cycle request to change the fetch address.
REQ-013 The block SHALL have ip_redirect_pc  input  32  the new fetch address; bits [1:0] are ignored and forced to 0.

Function
REQ-014 The block SHALL keep at most one imem request outstanding at any time.
REQ-015 The block SHALL implement the states IDLE, REQ, WAIT, VALID and DROP.
REQ-016 IDLE: the block SHALL go to REQ in the next cycle.
REQ-017 REQ: the block SHALL drive op_imem_req=1 and op_imem_addr=pc, and SHALL go to WAIT.
REQ-018 WAIT: on ip_imem_rvalid, the block SHALL register rdata into op_instr_from_imem, set op_pc=pc, set op_instr_valid=1, set pc<=pc+4 (mod 2^32) and go to VALID; otherwise it SHALL stay in WAIT.
REQ-019 VALID: the block SHALL hold op_instr_valid, op_instr_from_imem and op_pc stable while ip_stall=1.
REQ-020 VALID: when ip_stall=0, the block SHALL treat the instruction as consumed, clear op_instr_valid next cycle and go to REQ.
REQ-021 The instruction throughput SHALL be one per (2 + memory latency) cycles when there is no stall.
REQ-022 Redirect SHALL take priority over stall and over rvalid.
REQ-023 On a redirect, the block SHALL set pc<=ip_redirect_pc and op_instr_valid<=0 in the next cycle.
REQ-024 A redirect in WAIT without rvalid, or in REQ, SHALL move the block to DROP.
REQ-025 A redirect in WAIT with rvalid in the same cycle, or in VALID or IDLE, SHALL move the block to REQ.
REQ-026 DROP: the block SHALL discard the next rvalid and go to REQ; a further redirect in DROP SHALL update pc and stay in DROP.
REQ-027 An rvalid in IDLE, REQ or VALID SHALL be ignored.
REQ-028 op_imem_req SHALL be high only in REQ.
REQ-029 op_instr_valid SHALL never be high in IDLE, REQ, WAIT or DROP.
REQ-030 The pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-031 On ip_rst=1, the block SHALL immediately set the state to IDLE, pc=RESET_PC, op_pc=RESET_PC, op_imem_addr=RESET_PC, op_imem_req=0, op_instr_valid=0 and op_instr_from_imem=32'h0.
REQ-032 On reset during WAIT, the block SHALL discard the pending response; an rvalid in the first REQ after reset SHALL be ignored.
REQ-033 The first request after reset deassertion SHALL be issued 2 cycles later, to RESET_PC.

Verification
REQ-034 Basic fetch: reset, 1-cycle memory returning 32'h00000013 then 32'h00A00093 -> instructions are presented with op_pc 0x0 then 0x4, op_instr_valid high 1 cycle each, requests 3 cycles apart.
REQ-035 Stall: ip_stall=1 for 5 cycles while in VALID -> outputs are held for 6 cycles, no op_imem_req, and the next address is 0x8.
REQ-036 Redirect in flight: redirect to 0x100 one cycle after a request to 0x4, response returned 2 cycles later -> that response is dropped, the next request goes to 0x100, and no valid is presented for 0x4.
REQ-037 Simultaneous events: redirect to 0x200 in the same cycle as rvalid in WAIT -> data is discarded and a request to 0x200 is issued the next cycle.
REQ-038 Wrap: redirect to 0xFFFF_FFFC, then consume -> the next request goes to 0x0000_0000.
REQ-039 Reset mid-WAIT: assert ip_rst and return rvalid during reset -> all outputs are at reset values and the first request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues one imem read at a time,
// presents the returned instruction until consumed, and handles redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  output logic        op_imem_req,
  output logic [31:0] op_imem_addr,
  input  logic [31:0] ip_imem_rdata,
  input  logic        ip_imem_rvalid,
  output logic [31:0] op_instr_from_imem,
  output logic        op_instr_valid,
  output logic [31:0] op_pc,
  input  logic        ip_stall,
  input  logic        ip_redirect_valid,
  input  logic [31:0] ip_redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    DROP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] redirect_target;

  assign redirect_target = ip_redirect_pc & ~32'h0000_0003;

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = REQ;
      REQ:   state_next = ip_redirect_valid ? DROP : WAIT;
      WAIT: begin
        if (ip_redirect_valid) begin
          state_next = ip_imem_rvalid ? REQ : DROP;
        end else if (ip_imem_rvalid) begin
          state_next = VALID;
        end
      end
      VALID: begin
        if (ip_redirect_valid || !ip_stall) begin
          state_next = REQ;
        end
      end
      // A redirect coinciding with the dropped response still retires it;
      // waiting for another rvalid would deadlock with nothing outstanding.
      DROP: begin
        if (ip_imem_rvalid) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    op_imem_req  = (state == REQ);
    op_imem_addr = pc;
  end

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      pc                 <= RESET_PC;
      op_pc              <= RESET_PC;
      op_instr_valid     <= 1'b0;
      op_instr_from_imem <= '0;
    end else if (ip_redirect_valid) begin
      pc             <= redirect_target;
      op_instr_valid <= 1'b0;
    end else begin
      if (state == WAIT && ip_imem_rvalid) begin
        op_instr_from_imem <= ip_imem_rdata;
        op_pc              <= pc;
        op_instr_valid     <= 1'b1;
        pc                 <= pc + 32'd4;
      end else if (state == VALID && !ip_stall) begin
        op_instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: per-cycle input/expected-output table
// plus a hand-written reset-during-WAIT sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .ip_clk             (clk),
    .ip_rst             (rst),
    .op_imem_req        (imem_req),
    .op_imem_addr       (imem_addr),
    .ip_imem_rdata      (imem_rdata),
    .ip_imem_rvalid     (imem_rvalid),
    .op_instr_from_imem (instr),
    .op_instr_valid     (instr_valid),
    .op_pc              (pc),
    .ip_stall           (stall),
    .ip_redirect_valid  (redirect_valid),
    .ip_redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc);
    chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, e_req});
    chk({tag, ".addr"},  imem_addr,            e_addr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
    chk({tag, ".instr"}, instr,                e_instr);
    chk({tag, ".pc"},    pc,                   e_pc);
  endtask

  task automatic add(input logic rd, input logic [31:0] rp, input logic st, input logic rv,
                     input logic [31:0] dat, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.redir = rd; v.rpc = rp; v.stall = st; v.rvalid = rv; v.rdata = dat;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rd, input logic [31:0] rp, input logic st,
                       input logic rv, input logic [31:0] dat);
    redirect_valid = rd; redirect_pc = rp; stall = st; imem_rvalid = rv; imem_rdata = dat;
  endtask

  initial begin
    //  redir rpc           stall rv  rdata          req addr          vld instr          pc
    add(0, 0,            0, 0, 0,             0, 32'h0,        0, 32'h0,        32'h0);        // IDLE
    add(0, 0,            0, 0, 0,             1, 32'h0,        0, 32'h0,        32'h0);        // REQ 0
    add(0, 0,            0, 1, 32'h0000_0013, 0, 32'h0,        0, 32'h0,        32'h0);        // WAIT
    add(0, 0,            0, 0, 0,             0, 32'h4,        1, 32'h0000_0013, 32'h0);
    add(0, 0,            0, 0, 0,             1, 32'h4,        0, 32'h0000_0013, 32'h0);       // REQ 4
    add(0, 0,            0, 1, 32'h00A0_0093, 0, 32'h4,        0, 32'h0000_0013, 32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 0,          1, 0, 0,             0, 32'h8,        1, 32'h00A0_0093, 32'h4);       // stalled
    add(0, 0,            0, 0, 0,             0, 32'h8,        1, 32'h00A0_0093, 32'h4);
    add(0, 0,            0, 0, 0,             1, 32'h8,        0, 32'h00A0_0093, 32'h4);       // REQ 8
    add(0, 0,            0, 0, 0,             0, 32'h8,        0, 32'h00A0_0093, 32'h4);       // 2-cycle mem
    add(0, 0,            0, 1, 32'h1111_1111, 0, 32'h8,        0, 32'h00A0_0093, 32'h4);
    add(0, 0,            0, 0, 0,             0, 32'hC,        1, 32'h1111_1111, 32'h8);
    add(0, 0,            0, 0, 0,             1, 32'hC,        0, 32'h1111_1111, 32'h8);       // REQ C
    add(1, 32'h100,      0, 0, 0,             0, 32'hC,        0, 32'h1111_1111, 32'h8);       // WAIT redirect
    add(1, 32'h180,      0, 0, 0,             0, 32'h100,      0, 32'h1111_1111, 32'h8);       // DROP redirect
    add(0, 0,            0, 1, 32'hDEAD_BEEF, 0, 32'h180,      0, 32'h1111_1111, 32'h8);       // dropped
    add(0, 0,            0, 0, 0,             1, 32'h180,      0, 32'h1111_1111, 32'h8);
    add(1, 32'h203,      0, 1, 32'h1234_5678, 0, 32'h180,      0, 32'h1111_1111, 32'h8);       // redirect+rvalid
    add(0, 0,            0, 0, 0,             1, 32'h200,      0, 32'h1111_1111, 32'h8);
    add(0, 0,            0, 1, 32'h2222_2222, 0, 32'h200,      0, 32'h1111_1111, 32'h8);
    add(1, 32'hFFFF_FFFF,1, 0, 0,             0, 32'h204,      1, 32'h2222_2222, 32'h200);     // redirect beats stall
    add(0, 0,            0, 0, 0,             1, 32'hFFFF_FFFC,0, 32'h2222_2222, 32'h200);
    add(0, 0,            0, 1, 32'h3333_3333, 0, 32'hFFFF_FFFC,0, 32'h2222_2222, 32'h200);
    add(0, 0,            0, 0, 0,             0, 32'h0,        1, 32'h3333_3333, 32'hFFFF_FFFC); // wrapped
    add(1, 32'h300,      0, 0, 0,             1, 32'h0,        0, 32'h3333_3333, 32'hFFFF_FFFC); // REQ redirect
    add(0, 0,            0, 1, 32'h5555_5555, 0, 32'h300,      0, 32'h3333_3333, 32'hFFFF_FFFC);
    add(0, 0,            0, 1, 32'h6666_6666, 1, 32'h300,      0, 32'h3333_3333, 32'hFFFF_FFFC); // rvalid in REQ
    add(0, 0,            0, 0, 0,             0, 32'h300,      0, 32'h3333_3333, 32'hFFFF_FFFC);
    add(0, 0,            0, 1, 32'h7777_7777, 0, 32'h300,      0, 32'h3333_3333, 32'hFFFF_FFFC);
    add(0, 0,            1, 1, 32'h8888_8888, 0, 32'h304,      1, 32'h7777_7777, 32'h300);     // rvalid in VALID
    add(0, 0,            0, 0, 0,             0, 32'h304,      1, 32'h7777_7777, 32'h300);
    add(0, 0,            0, 0, 0,             1, 32'h304,      0, 32'h7777_7777, 32'h300);

    rst = 1'b1;
    drive(0, 0, 0, 1, 32'hCAFE_F00D);
    #12;
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].stall, vecs[i].rvalid, vecs[i].rdata);
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_instr, vecs[i].e_pc);
      @(posedge clk); #1;
    end

    // Now in WAIT for 0x304: reset with a response arriving during reset.
    drive(0, 0, 0, 1, 32'h9999_9999);
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_all("rst_held", 0, 32'h0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk_all("post_rst_idle", 0, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 32'hAAAA_AAAA);
    chk_all("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    chk_all("post_rst_wait", 0, 32'h0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 1, 32'hBBBB_BBBB);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    chk_all("post_rst_valid", 0, 32'h4, 1, 32'hBBBB_BBBB, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
